sc_lane_shifter: RTL and testbench

//  Consumer of the velocity-tick strobe: holds one traffic lane as a W-bit occupancy

---
 rtl/sc_lane_shifter_if.sv | 25 ++
 rtl/sc_lane_shifter.sv | 95 +++++++++
 tb/tb_sc_lane_shifter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sc_lane_shifter_if.sv
// Lane shifter bus: tick, enable, load and frog inputs; pattern, shift and hit outputs.
interface sc_lane_shifter_if #(
    parameter int unsigned W = 8
);
    logic         SC_LANE_TICK_In;
    logic         SC_LANE_HAB_In;
    logic         SC_LANE_LOAD_In;
    logic [W-1:0] SC_LANE_DATA_In;
    logic [W-1:0] SC_LANE_FROG_In;
    logic [W-1:0] SC_LANE_Out;
    logic         SC_LANE_SHIFT_Out;
    logic         SC_LANE_HIT_Out;

    modport master (
        output SC_LANE_TICK_In, SC_LANE_HAB_In, SC_LANE_LOAD_In,
               SC_LANE_DATA_In, SC_LANE_FROG_In,
        input  SC_LANE_Out, SC_LANE_SHIFT_Out, SC_LANE_HIT_Out
    );

    modport slave (
        input  SC_LANE_TICK_In, SC_LANE_HAB_In, SC_LANE_LOAD_In,
               SC_LANE_DATA_In, SC_LANE_FROG_In,
        output SC_LANE_Out, SC_LANE_SHIFT_Out, SC_LANE_HIT_Out
    );
endinterface

// File: rtl/sc_lane_shifter.sv
// Traffic lane occupancy register: rotates one column every LANE_STEP_DIV velocity
// ticks and flags overlap with the frog column.
module sc_lane_shifter #(
    parameter int unsigned LANE_DATAWIDTH = 8,
    parameter bit          LANE_DIR_RIGHT = 1'b1,
    parameter int unsigned LANE_STEP_DIV  = 1
) (
    input  logic                SC_LANE_CLOCK_50,
    input  logic                SC_LANE_RESET_InLow,
    sc_lane_shifter_if.slave    bus
);
    localparam int unsigned W     = LANE_DATAWIDTH;
    localparam int unsigned DIV_W = (LANE_STEP_DIV > 1) ? $clog2(LANE_STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LANE_STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [W-1:0]       pattern, pattern_next;
    logic [DIV_W-1:0]   divider, divider_next;
    logic               shift_q, shift_next;
    logic               hit_q, hit_next;
    logic [W-1:0]       pattern_rot_c;

    // Lossless one-column rotation in the configured direction
    always_comb begin
        if (LANE_DIR_RIGHT)
            pattern_rot_c = {pattern[W-2:0], pattern[W-1]};
        else
            pattern_rot_c = {pattern[0], pattern[W-1:1]};
    end

    always_ff @(posedge SC_LANE_CLOCK_50) begin
        if (!SC_LANE_RESET_InLow) begin
            state   <= ST_IDLE;
            pattern <= '0;
            divider <= '0;
            shift_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pattern <= pattern_next;
            divider <= divider_next;
            shift_q <= shift_next;
            hit_q   <= hit_next;
        end
    end

    // Load overrides everything; enable is checked before the tick in RUN
    always_comb begin
        state_next   = state;
        pattern_next = pattern;
        divider_next = divider;
        shift_next   = 1'b0;

        if (bus.SC_LANE_LOAD_In) begin
            pattern_next = bus.SC_LANE_DATA_In;
            divider_next = '0;
            state_next   = bus.SC_LANE_HAB_In ? ST_RUN : ST_HOLD;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!bus.SC_LANE_HAB_In) begin
                        state_next = ST_HOLD;
                    end else if (bus.SC_LANE_TICK_In) begin
                        if (divider == DIV_LAST) begin
                            divider_next = '0;
                            pattern_next = pattern_rot_c;
                            shift_next   = 1'b1;
                        end else begin
                            divider_next = divider + DIV_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.SC_LANE_HAB_In)
                        state_next = ST_RUN;
                end
                default: begin
                    state_next = state;
                end
            endcase
        end

        hit_next = |(pattern_next & bus.SC_LANE_FROG_In);
    end

    assign bus.SC_LANE_Out       = pattern;
    assign bus.SC_LANE_SHIFT_Out = shift_q;
    assign bus.SC_LANE_HIT_Out   = hit_q;
endmodule

// File: tb/tb_sc_lane_shifter.sv
// Scoreboard bench for sc_lane_shifter: three configurations share one stimulus stream.
module tb_sc_lane_shifter;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    sc_lane_shifter_if #(.W(8)) if_a ();
    sc_lane_shifter_if #(.W(8)) if_b ();
    sc_lane_shifter_if #(.W(8)) if_c ();

    sc_lane_shifter #(.LANE_DATAWIDTH(8), .LANE_DIR_RIGHT(1'b1), .LANE_STEP_DIV(1)) dut_a (
        .SC_LANE_CLOCK_50(clk), .SC_LANE_RESET_InLow(rst_n), .bus(if_a.slave));
    sc_lane_shifter #(.LANE_DATAWIDTH(8), .LANE_DIR_RIGHT(1'b1), .LANE_STEP_DIV(3)) dut_b (
        .SC_LANE_CLOCK_50(clk), .SC_LANE_RESET_InLow(rst_n), .bus(if_b.slave));
    sc_lane_shifter #(.LANE_DATAWIDTH(8), .LANE_DIR_RIGHT(1'b0), .LANE_STEP_DIV(1)) dut_c (
        .SC_LANE_CLOCK_50(clk), .SC_LANE_RESET_InLow(rst_n), .bus(if_c.slave));

    typedef struct {
        int         sel;
        logic [7:0] out;
        logic       shift;
        logic       hit;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Drive all three lanes identically; expectation targets one of them
    task automatic step(input int sel, input string nm, input logic rst, input logic load,
                        input logic tick, input logic hab, input logic [7:0] data,
                        input logic [7:0] frog, input logic [7:0] eo, input logic es,
                        input logic eh);
        exp_t e;
        rst_n = rst;
        if_a.SC_LANE_LOAD_In = load; if_a.SC_LANE_TICK_In = tick; if_a.SC_LANE_HAB_In = hab;
        if_a.SC_LANE_DATA_In = data; if_a.SC_LANE_FROG_In = frog;
        if_b.SC_LANE_LOAD_In = load; if_b.SC_LANE_TICK_In = tick; if_b.SC_LANE_HAB_In = hab;
        if_b.SC_LANE_DATA_In = data; if_b.SC_LANE_FROG_In = frog;
        if_c.SC_LANE_LOAD_In = load; if_c.SC_LANE_TICK_In = tick; if_c.SC_LANE_HAB_In = hab;
        if_c.SC_LANE_DATA_In = data; if_c.SC_LANE_FROG_In = frog;
        @(posedge clk);
        e.sel = sel; e.out = eo; e.shift = es; e.hit = eh; e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle
    always begin
        @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] ao;
            logic       as, ah;
            e = exp_q.pop_front();
            case (e.sel)
                0:       begin ao = if_a.SC_LANE_Out; as = if_a.SC_LANE_SHIFT_Out; ah = if_a.SC_LANE_HIT_Out; end
                1:       begin ao = if_b.SC_LANE_Out; as = if_b.SC_LANE_SHIFT_Out; ah = if_b.SC_LANE_HIT_Out; end
                default: begin ao = if_c.SC_LANE_Out; as = if_c.SC_LANE_SHIFT_Out; ah = if_c.SC_LANE_HIT_Out; end
            endcase
            checks++;
            if (ao === e.out && as === e.shift && ah === e.hit)
                passed++;
            else
                $display("FAIL %s: got out=%b shift=%b hit=%b, expected out=%b shift=%b hit=%b",
                         e.name, ao, as, ah, e.out, e.shift, e.hit);
        end
    end

    logic [7:0] t2_exp [8];

    initial begin
        t2_exp[0] = 8'b0000_0110; t2_exp[1] = 8'b0000_1100;
        t2_exp[2] = 8'b0001_1000; t2_exp[3] = 8'b0011_0000;
        t2_exp[4] = 8'b0110_0000; t2_exp[5] = 8'b1100_0000;
        t2_exp[6] = 8'b1000_0001; t2_exp[7] = 8'b0000_0011;

        // Reset dominates load, tick and frog
        for (int s = 0; s < 3; s++)
            step(s, "reset", 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // DIV=1 rotate right with wrap, single-cycle shift pulses
        step(0, "t2_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0011, 8'h00, 8'b0000_0011, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(0, "t2_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, t2_exp[i], 1'b1, 1'b0);
            step(0, "t2_idle", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, t2_exp[i], 1'b0, 1'b0);
        end

        // DIV=3: ticks in IDLE ignored, then shift on every third tick
        step(1, "t3_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1, "t3_idle_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1, "t3_idle_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1, "t3_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0001, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(1, "t3_tick1", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(1, "t3_tick2", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(1, "t3_tick3", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b1, 1'b0);
        step(1, "t3_gap",   1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        step(1, "t3_tick4", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        step(1, "t3_tick5", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        step(1, "t3_tick6", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0100, 1'b1, 1'b0);

        // Pause: tick with HAB falling is dropped, held ticks ignored
        step(0, "t4_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(0, "t4_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0001, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(0, "t4_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b1, 1'b0);
        step(0, "t4_hab_fall_tick", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(0, "t4_hold_tick", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        step(0, "t4_resume", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'b0000_0010, 1'b0, 1'b0);
        step(0, "t4_tick_after", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0000_0100, 1'b1, 1'b0);

        // Collision flag follows the pattern being written
        step(0, "t5_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(0, "t5_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0010, 8'b0000_0100, 8'b0000_0010, 1'b0, 1'b0);
        step(0, "t5_hit_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'b0000_0100, 8'b0000_0100, 1'b1, 1'b1);
        step(0, "t5_hit_hold", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'b0000_0100, 8'b0000_0100, 1'b0, 1'b1);
        step(0, "t5_leave", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'b0000_0100, 8'b0000_1000, 1'b1, 1'b0);
        step(0, "t5_frog_on", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'b0000_1000, 8'b0000_1000, 1'b0, 1'b1);
        step(0, "t5_frog_off", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'b0000_1000, 1'b0, 1'b0);

        // Load beats tick; leftward rotation with wrap; load into HOLD; reset mid-run
        step(2, "t6_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(2, "t6_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0001, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(2, "t6_load_tick", 1'b1, 1'b1, 1'b1, 1'b1, 8'b1010_0000, 8'h00, 8'b1010_0000, 1'b0, 1'b0);
        step(2, "t6_tick_left", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b0101_0000, 1'b1, 1'b0);
        step(2, "t6_load_wrap", 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0001, 8'h00, 8'b0000_0001, 1'b0, 1'b0);
        step(2, "t6_wrap", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b1000_0000, 1'b1, 1'b0);
        step(2, "t6_load_hold", 1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0011, 8'h00, 8'b0000_0011, 1'b0, 1'b0);
        step(2, "t6_hold_tick", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'b0000_0011, 1'b0, 1'b0);
        step(2, "t6_resume", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'b0000_0011, 1'b0, 1'b0);
        step(2, "t6_run_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'b1000_0001, 1'b1, 1'b0);
        step(2, "t6_reset_mid", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
